// File: rtl/expr_pkg.sv
// ---------------------------------------------------------------------------
// expr_pkg
// Shared definitions for the expression solver control path: the FSM state
// encoding, the datapath mux select codes, the ALU op codes and the bundle of
// control lines that the decoder hands back to the FSM wrapper.
// No ports; imported by expression_control and control_decode.
// ---------------------------------------------------------------------------
package expr_pkg;

  // All eight 3-bit encodings are used, but the FSM still treats anything
  // unexpected as a reason to fall back to IDLE.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    MUL_AX = 3'd2,
    ADD_B  = 3'd3,
    MUL_X  = 3'd4,
    MUL_BX = 3'd5,
    ADD_C  = 3'd6,
    DONE   = 3'd7
  } state_t;

  // mux0: constant source feeding the other two muxes
  localparam logic [1:0] SEL0_ZERO = 2'b00;
  localparam logic [1:0] SEL0_A    = 2'b01;
  localparam logic [1:0] SEL0_B    = 2'b10;
  localparam logic [1:0] SEL0_C    = 2'b11;

  // mux1: ALU operand b
  localparam logic [1:0] SEL1_M0   = 2'b00;
  localparam logic [1:0] SEL1_X    = 2'b01;
  localparam logic [1:0] SEL1_S    = 2'b10;
  localparam logic [1:0] SEL1_H    = 2'b11;

  // mux2: ALU operand a
  localparam logic [1:0] SEL2_X    = 2'b00;
  localparam logic [1:0] SEL2_M0   = 2'b01;
  localparam logic [1:0] SEL2_S    = 2'b10;
  localparam logic [1:0] SEL2_H    = 2'b11;

  // ALU operation select
  localparam logic H_ADD = 1'b0;
  localparam logic H_MUL = 1'b1;

  // Every Moore output that depends on the state alone
  typedef struct packed {
    logic       lx;
    logic       ls;
    logic       lh;
    logic       h;
    logic [1:0] m0;
    logic [1:0] m1;
    logic [1:0] m2;
    logic       busy;
    logic       done;
  } ctrl_t;

endpackage

// File: rtl/control_decode.sv
// ---------------------------------------------------------------------------
// control_decode
// Purely combinational state decoder for the expression solver. Maps the
// current FSM state onto the datapath control lines and the busy/done status.
// Ports:
//   state_i  current FSM state
//   ctrl_o   {LX, LS, LH, H, M0, M1, M2, busy, done}
// ---------------------------------------------------------------------------
module control_decode
  import expr_pkg::*;
(
  input  state_t state_i,
  output ctrl_t  ctrl_o
);

  // Start from "everything idle" so that IDLE and any unexpected state drive
  // no loads, ADD on the ALU and all muxes at 00; each compute state then
  // overrides only the lines it actually needs.
  always_comb begin
    ctrl_o = '0;
    case (state_i)
      LOAD: begin
        ctrl_o.lx   = 1'b1;
        ctrl_o.busy = 1'b1;
      end
      MUL_AX: begin
        ctrl_o.m0   = SEL0_A;
        ctrl_o.m1   = SEL1_M0;
        ctrl_o.m2   = SEL2_X;
        ctrl_o.h    = H_MUL;
        ctrl_o.lh   = 1'b1;
        ctrl_o.busy = 1'b1;
      end
      ADD_B: begin
        ctrl_o.m0   = SEL0_B;
        ctrl_o.m1   = SEL1_H;
        ctrl_o.m2   = SEL2_M0;
        ctrl_o.h    = H_ADD;
        ctrl_o.lh   = 1'b1;
        ctrl_o.busy = 1'b1;
      end
      MUL_X: begin
        ctrl_o.m1   = SEL1_H;
        ctrl_o.m2   = SEL2_X;
        ctrl_o.h    = H_MUL;
        ctrl_o.lh   = 1'b1;
        ctrl_o.busy = 1'b1;
      end
      MUL_BX: begin
        ctrl_o.m0   = SEL0_B;
        ctrl_o.m1   = SEL1_M0;
        ctrl_o.m2   = SEL2_X;
        ctrl_o.h    = H_MUL;
        ctrl_o.lh   = 1'b1;
        ctrl_o.busy = 1'b1;
      end
      ADD_C: begin
        ctrl_o.m0   = SEL0_C;
        ctrl_o.m1   = SEL1_H;
        ctrl_o.m2   = SEL2_M0;
        ctrl_o.h    = H_ADD;
        ctrl_o.ls   = 1'b1;
        ctrl_o.busy = 1'b1;
      end
      DONE: begin
        ctrl_o.done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/expression_control.sv
// ---------------------------------------------------------------------------
// expression_control
// Control unit sequencing the operative datapath through S = A*X^2 + B*X + C
// (mode = 0) or S = B*X + C (mode = 1), with a start/done handshake.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   start, mode     evaluation request and form select (sampled in IDLE)
//   zero, overflow  datapath flags (Reg_S == 0, current ALU op overflowed)
//   LX, LS, LH      register load enables for Reg_X, Reg_S, Reg_H
//   H               ALU op select
//   M0, M1, M2      datapath mux selects
//   busy, done      status: busy LOAD..ADD_C, done one-cycle pulse
//   ovf             sticky overflow of the current evaluation
//   result_zero     zero flag captured at DONE
// ---------------------------------------------------------------------------
module expression_control
  import expr_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       mode,
  input  logic       zero,
  input  logic       overflow,
  output logic       LX,
  output logic       LS,
  output logic       LH,
  output logic       H,
  output logic [1:0] M0,
  output logic [1:0] M1,
  output logic [1:0] M2,
  output logic       busy,
  output logic       done,
  output logic       ovf,
  output logic       result_zero
);

  state_t state_q, state_d;
  logic   mode_q, mode_d;
  logic   ovf_q, ovf_d;
  logic   resultZero_q, resultZero_d;
  ctrl_t  ctrl;

  // Next-state and flag logic. The sticky overflow only accumulates in the
  // five compute states so that a stray ALU flag in IDLE/LOAD/DONE cannot
  // pollute the result; mode is latched once with start and never again
  // until the FSM is back in IDLE.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    ovf_d        = ovf_q;
    resultZero_d = resultZero_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = LOAD;
          mode_d       = mode;
          ovf_d        = 1'b0;
          resultZero_d = 1'b0;
        end
      end
      LOAD:   state_d = mode_q ? MUL_BX : MUL_AX;
      MUL_AX: begin
        state_d = ADD_B;
        ovf_d   = ovf_q | overflow;
      end
      ADD_B: begin
        state_d = MUL_X;
        ovf_d   = ovf_q | overflow;
      end
      MUL_X: begin
        state_d = ADD_C;
        ovf_d   = ovf_q | overflow;
      end
      MUL_BX: begin
        state_d = ADD_C;
        ovf_d   = ovf_q | overflow;
      end
      ADD_C: begin
        state_d = DONE;
        ovf_d   = ovf_q | overflow;
      end
      DONE: begin
        state_d      = IDLE;
        resultZero_d = zero;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and flag registers. Reset takes priority over everything,
  // including a start presented in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      mode_q       <= 1'b0;
      ovf_q        <= 1'b0;
      resultZero_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      ovf_q        <= ovf_d;
      resultZero_q <= resultZero_d;
    end
  end

  control_decode u_decode (
    .state_i (state_q),
    .ctrl_o  (ctrl)
  );

  assign LX          = ctrl.lx;
  assign LS          = ctrl.ls;
  assign LH          = ctrl.lh;
  assign H           = ctrl.h;
  assign M0          = ctrl.m0;
  assign M1          = ctrl.m1;
  assign M2          = ctrl.m2;
  assign busy        = ctrl.busy;
  assign done        = ctrl.done;
  assign ovf         = ovf_q;
  assign result_zero = resultZero_q;

endmodule

// File: tb/tb_expression_control.sv
// ---------------------------------------------------------------------------
// tb_expression_control
// Drives expression_control together with a behavioural 16-bit datapath
// (Reg_X, Reg_S, Reg_H, three muxes and an add/multiply ALU) and compares
// each finished evaluation against an arithmetic reference held in a queue.
// ---------------------------------------------------------------------------
module tb_expression_control;
  import expr_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic mode = 1'b0;
  logic zero, overflow;
  logic LX, LS, LH, H, busy, done, ovf, result_zero;
  logic [1:0] M0, M1, M2;

  logic [15:0] inA = '0, inB = '0, inC = '0, inX = '0;
  logic [15:0] regX = '0, regS = '0, regH = '0;
  logic [15:0] mux0Out, aluA, aluB, aluOut;
  logic [31:0] prod;
  logic [16:0] sum;
  logic [13:0] ctrlVec;

  int cyc = 0;
  int lhTotal = 0;
  int evalCount = 0;
  int failCount = 0;

  typedef struct {
    logic [15:0] s;
    logic        ovf;
    logic        zero;
    int          lat;
    int          lh;
    int          startCyc;
    int          lhBase;
  } expT;

  expT sb[$];

  always #5 clk = ~clk;

  expression_control dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .mode        (mode),
    .zero        (zero),
    .overflow    (overflow),
    .LX          (LX),
    .LS          (LS),
    .LH          (LH),
    .H           (H),
    .M0          (M0),
    .M1          (M1),
    .M2          (M2),
    .busy        (busy),
    .done        (done),
    .ovf         (ovf),
    .result_zero (result_zero)
  );

  assign ctrlVec = {LX, LS, LH, H, M0, M1, M2, busy, done, ovf, result_zero};

  // Datapath muxes and ALU, built from the select tables of the datapath.
  always_comb begin
    case (M0)
      2'b00:   mux0Out = 16'd0;
      2'b01:   mux0Out = inA;
      2'b10:   mux0Out = inB;
      default: mux0Out = inC;
    endcase
    case (M1)
      2'b00:   aluB = mux0Out;
      2'b01:   aluB = regX;
      2'b10:   aluB = regS;
      default: aluB = regH;
    endcase
    case (M2)
      2'b00:   aluA = regX;
      2'b01:   aluA = mux0Out;
      2'b10:   aluA = regS;
      default: aluA = regH;
    endcase
    prod = {16'd0, aluA} * {16'd0, aluB};
    sum  = {1'b0, aluA} + {1'b0, aluB};
    if (H == 1'b1) begin
      aluOut   = prod[15:0];
      overflow = |prod[31:16];
    end else begin
      aluOut   = sum[15:0];
      overflow = sum[16];
    end
  end

  assign zero = (regS == 16'd0);

  // Datapath registers plus cycle and LH-pulse counters used for latency and
  // state-path checks.
  always @(posedge clk) begin
    if (LX) regX <= inX;
    if (LS) regS <= aluOut;
    if (LH) regH <= aluOut;
    cyc <= cyc + 1;
    if (LH) lhTotal <= lhTotal + 1;
  end

  // Arithmetic reference: step-by-step 16-bit evaluation with overflow.
  function automatic expT refEval(input logic [15:0] a, b, c, x, input logic m);
    expT e;
    logic [31:0] p;
    logic [16:0] s17;
    logic [15:0] h;
    logic o;
    if (!m) begin
      p   = {16'd0, a} * {16'd0, x};
      o   = |p[31:16];
      h   = p[15:0];
      s17 = {1'b0, h} + {1'b0, b};
      o   = o | s17[16];
      h   = s17[15:0];
      p   = {16'd0, h} * {16'd0, x};
      o   = o | (|p[31:16]);
      h   = p[15:0];
    end else begin
      p = {16'd0, b} * {16'd0, x};
      o = |p[31:16];
      h = p[15:0];
    end
    s17      = {1'b0, h} + {1'b0, c};
    o        = o | s17[16];
    e.s      = s17[15:0];
    e.ovf    = o;
    e.zero   = (s17[15:0] == 16'd0);
    e.lat    = m ? 4 : 6;
    e.lh     = m ? 1 : 3;
    e.startCyc = 0;
    e.lhBase   = 0;
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    evalCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present operands and raise start; optionally queue the expected outcome.
  task automatic applyStimulus(input logic [15:0] a, b, c, x, input logic m, input bit expectIt);
    expT e;
    inA   = a;
    inB   = b;
    inC   = c;
    inX   = x;
    mode  = m;
    start = 1'b1;
    if (expectIt) begin
      e          = refEval(a, b, c, x, m);
      e.startCyc = cyc;
      e.lhBase   = lhTotal;
      sb.push_back(e);
    end
  endtask

  // Wait (bounded) for done, pop the oldest expectation and compare.
  task automatic waitDone(input string tag);
    int n;
    expT e;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, " done"}, 32'(done), 32'd1);
    checkOutput({tag, " sb"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput({tag, " latency"}, 32'(cyc - e.startCyc), 32'(e.lat));
      checkOutput({tag, " result"}, 32'(regS), 32'(e.s));
      checkOutput({tag, " ovf"}, 32'(ovf), 32'(e.ovf));
      checkOutput({tag, " lh pulses"}, 32'(lhTotal - e.lhBase), 32'(e.lh));
      @(negedge clk);
      checkOutput({tag, " done pulse"}, 32'(done), 32'd0);
      checkOutput({tag, " result_zero"}, 32'(result_zero), 32'(e.zero));
      checkOutput({tag, " ovf held"}, 32'(ovf), 32'(e.ovf));
    end
  endtask

  initial begin
    int doneSeen;
    $display("[TB] expression_control bench starting");

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("reset outputs", 32'(ctrlVec), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle outputs", 32'(ctrlVec), 32'd0);

    // Quadratic: 2*25 + 3*5 + 4 = 69
    applyStimulus(16'd2, 16'd3, 16'd4, 16'd5, 1'b0, 1'b1);
    @(negedge clk);
    start = 1'b0;
    waitDone("quad");

    // Linear, A ignored: 3*5 + 4 = 19
    applyStimulus(16'd7, 16'd3, 16'd4, 16'd5, 1'b1, 1'b1);
    @(negedge clk);
    start = 1'b0;
    waitDone("linear");

    // Zero result, then a non-zero one
    applyStimulus(16'd0, 16'd0, 16'd0, 16'd9, 1'b0, 1'b1);
    @(negedge clk);
    start = 1'b0;
    waitDone("zero");
    applyStimulus(16'd0, 16'd0, 16'd1, 16'd9, 1'b0, 1'b1);
    @(negedge clk);
    start = 1'b0;
    waitDone("nonzero");

    // Overflow in MUL_X (A*X^2 = 2^16), then a clean run
    applyStimulus(16'h0100, 16'd0, 16'd0, 16'h0010, 1'b0, 1'b1);
    @(negedge clk);
    start = 1'b0;
    waitDone("overflow");
    applyStimulus(16'd2, 16'd3, 16'd4, 16'd5, 1'b0, 1'b1);
    @(negedge clk);
    start = 1'b0;
    waitDone("clean");

    // Protocol: start raised in MUL_X (with mode flipped) and held
    applyStimulus(16'd2, 16'd3, 16'd4, 16'd5, 1'b0, 1'b1);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("proto in mul_x", 32'({LH, H, M1, M2}), 32'({1'b1, H_MUL, SEL1_H, SEL2_X}));
    start = 1'b1;
    mode  = 1'b1;
    waitDone("proto first");
    checkOutput("proto idle", 32'({busy, LX}), 32'd0);
    applyStimulus(16'd2, 16'd3, 16'd4, 16'd5, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("proto load", 32'({LX, busy}), 32'b11);
    start = 1'b0;
    waitDone("proto second");

    // Reset mid-run in ADD_B
    applyStimulus(16'd2, 16'd3, 16'd4, 16'd5, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst in add_b", 32'({LH, H, M0, M1, M2}), 32'({1'b1, H_ADD, SEL0_B, SEL1_H, SEL2_M0}));
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst mid-run outputs", 32'(ctrlVec), 32'd0);
    rst = 1'b0;
    doneSeen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done === 1'b1) doneSeen++;
    end
    checkOutput("rst no done", 32'(doneSeen), 32'd0);

    // Simultaneous reset and start: reset wins
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    checkOutput("rst+start idle", 32'({busy, LX}), 32'd0);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    checkOutput("rst+start stays idle", 32'(ctrlVec), 32'd0);

    // Fresh run after reset
    applyStimulus(16'd2, 16'd3, 16'd4, 16'd5, 1'b0, 1'b1);
    @(negedge clk);
    start = 1'b0;
    waitDone("post reset");

    checkOutput("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", evalCount, failCount);
    $finish;
  end

endmodule

// File: doc/expression_control.md
Name: expression_control

Overview:
- Control unit (FSM) that sequences the `operative` datapath through evaluation of the expression S = A·X² + B·X + C, or the linear variant S = B·X + C.
- Drives every datapath control line: LX, LS, LH, H, M0, M1 and M2.
- Observes the datapath status flags zero and overflow.
- Provides a start/done handshake to the surrounding system. Together with `operative` it forms the expression solver top level.

Parameters:
- H_ADD, 1'b0: ALU op code for addition.
- H_MUL, 1'b1: ALU op code for multiplication.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new evaluation; sampled only in IDLE.
- mode  input  1  0 = quadratic (A·X²+B·X+C), 1 = linear (B·X+C); captured with start.
- zero  input  1  datapath flag: Reg_S == 0.
- overflow  input  1  datapath flag: the current ALU operation overflowed (combinational).
- LX  output  1  load Reg_X from input_X.
- LS  output  1  load Reg_S from the ALU output.
- LH  output  1  load Reg_H from the ALU output.
- H  output  1  ALU operation select.
- M0  output  2  mux0 select: 00 = 0, 01 = A, 10 = B, 11 = C.
- M1  output  2  mux1 (ALU operand b) select: 00 = M0_out, 01 = Reg_X, 10 = Reg_S, 11 = Reg_H.
- M2  output  2  mux2 (ALU operand a) select: 00 = Reg_X, 01 = M0_out, 10 = Reg_S, 11 = Reg_H.
- busy  output  1  high from LOAD through ADD_C inclusive.
- done  output  1  one-cycle pulse; Reg_S holds a valid result.
- ovf  output  1  sticky overflow for the current evaluation; valid while done is high, held until the next start.
- result_zero  output  1  zero sampled in DONE, held until the next start.

Behaviour:
- Reset: state = IDLE. All outputs are 0: LX, LS and LH deasserted; M0, M1 and M2 = 00; H = H_ADD; busy, done, ovf and result_zero = 0.
- Control outputs are Moore, decoded from the state only.
- In any state not listed below, every load enable is 0 and the muxes are at 00.
- States and per-state outputs:
  - IDLE: no loads.
    - If start: capture mode, clear ovf and result_zero, go to LOAD.
  - LOAD: LX = 1.
    - Next state: MUL_AX if mode = 0, else MUL_BX.
  - MUL_AX: M0 = 01, M1 = 00, M2 = 00, H = H_MUL, LH = 1 (Reg_H <= A·X). Next: ADD_B.
  - ADD_B: M0 = 10, M1 = 11, M2 = 01, H = H_ADD, LH = 1 (Reg_H <= Reg_H + B). Next: MUL_X.
  - MUL_X: M1 = 11, M2 = 00, H = H_MUL, LH = 1 (Reg_H <= Reg_H·X). Next: ADD_C.
  - MUL_BX: M0 = 10, M1 = 00, M2 = 00, H = H_MUL, LH = 1 (Reg_H <= B·X). Next: ADD_C.
  - ADD_C: M0 = 11, M1 = 11, M2 = 01, H = H_ADD, LS = 1 (Reg_S <= Reg_H + C). Next: DONE.
  - DONE: done = 1, busy = 0; result_zero <= zero. Next: IDLE.
- Latency, start to done pulse:
  - quadratic: 6 cycles (LOAD + 4 compute states + DONE);
  - linear: 4 cycles.
- Back-to-back evaluations: a new evaluation is accepted from IDLE at the earliest one cycle after DONE.
- Overflow: in each compute state (MUL_AX, ADD_B, MUL_X, MUL_BX, ADD_C), ovf <= ovf | overflow.
  - ovf is never cleared mid-run.
  - Overflow does not abort the sequence; the result is the truncated 16-bit value.
- start while not in IDLE: ignored; mode is not re-captured.
- start held high continuously: a new evaluation begins on each return to IDLE.
- Simultaneous rst and start: rst wins; the FSM stays in IDLE.
- rst mid-run: next cycle is IDLE with all outputs at their reset values; no done pulse. Datapath register contents are don't-care.
- Unused state encodings: recover to IDLE on the next clock.

Decomposition:
- Shared package `expr_pkg`:
  - state enum (IDLE, LOAD, MUL_AX, ADD_B, MUL_X, MUL_BX, ADD_C, DONE);
  - mux select constants: SEL0_ZERO/A/B/C, SEL1_M0/X/S/H, SEL2_X/M0/S/H;
  - ALU op constants H_ADD and H_MUL.
- Sub-module `control_decode`: purely combinational, state → {LX, LS, LH, H, M0, M1, M2, busy, done}. The FSM register and the sticky flags stay in `expression_control`.

Test Plan:
- Bench setup: `expression_control` connected to `operative`.
- Quadratic: A = 2, B = 3, C = 4, X = 5, mode = 0, 1-cycle start → done exactly 6 cycles after start; result = 69; ovf = 0; result_zero = 0.
- Linear: B = 3, C = 4, X = 5 (A = 7, ignored), mode = 1 → done after 4 cycles; result = 19; MUL_AX, ADD_B and MUL_X never visited.
- Zero: A = 0, B = 0, C = 0, X = 9, mode = 0 → result = 0, result_zero = 1. The following run with C = 1 → result_zero = 0.
- Overflow: A = 16'h0100, B = 0, C = 0, X = 8'h10, mode = 0 (A·X² = 2^16) → ovf = 1 at done, result = 0. The next clean run clears ovf to 0.
- Protocol: start pulsed in MUL_X and held through DONE → the first run completes normally; the second run's LOAD occurs in the cycle after the return to IDLE.
- Reset: rst asserted in ADD_B → next cycle IDLE, all control outputs 0, no done pulse. A fresh start then completes with the correct result.
